// File: rtl/instr_dispatch_fsm.sv
// instr_dispatch_fsm: decodes 16-bit instruction words and sequences one execution FSM at a time.
// Define DISPATCH_TIMEOUT_EN to add the WAIT watchdog and its timeout_err output.
module instr_dispatch_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic [3:0]  fsm_done,
    output logic [3:0]  fsm_start,
    output logic [5:0]  source,
    output logic [5:0]  dest,
    output logic        busy,
    output logic        instr_retired,
    output logic        illegal_op,
`ifdef DISPATCH_TIMEOUT_EN
    output logic        timeout_err,
`endif
    output logic [7:0]  retire_count
);
    typedef enum logic [2:0] {IDLE, DECODE, START, WAIT, RETIRE} state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [5:0]  src_q, src_d;
    logic [5:0]  dst_q, dst_d;
    logic [3:0]  start_q, start_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        retired_q, retired_d;
    logic        illegal_q, illegal_d;
    logic [7:0]  count_q, count_d;
`ifdef DISPATCH_TIMEOUT_EN
    logic [7:0]  wdog_q, wdog_d;
    logic        tmo_q, tmo_d;
`endif

    // Outputs are registered by computing them from the next state.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        start_d   = 4'b0000;
        retired_d = 1'b0;
        illegal_d = 1'b0;
        count_d   = count_q;
`ifdef DISPATCH_TIMEOUT_EN
        wdog_d    = wdog_q;
        tmo_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d      = instr[15:12];
                    src_d     = instr[11:6];
                    dst_d     = instr[5:0];
                    illegal_d = instr[15:14] != 2'b00;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                state_d = (op_q[3:2] == 2'b00) ? START : IDLE;
                start_d = (op_q[3:2] == 2'b00) ? 4'b0001 << op_q[1:0] : 4'b0000;
            end
            START: begin
                state_d = WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                wdog_d  = 8'd0;
`endif
            end
            WAIT: begin
`ifdef DISPATCH_TIMEOUT_EN
                wdog_d = wdog_q + 8'd1;
`endif
                if (fsm_done[op_q[1:0]]) begin
                    state_d   = RETIRE;
                    retired_d = 1'b1;
                    count_d   = count_q + 8'd1;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (wdog_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end
`endif
            end
            RETIRE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= 4'd0;
            src_q     <= 6'd0;
            dst_q     <= 6'd0;
            start_q   <= 4'd0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            retired_q <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= 8'd0;
`ifdef DISPATCH_TIMEOUT_EN
            wdog_q    <= 8'd0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            start_q   <= start_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
`ifdef DISPATCH_TIMEOUT_EN
            wdog_q    <= wdog_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign instr_ready   = ready_q;
    assign fsm_start     = start_q;
    assign source        = src_q;
    assign dest          = dst_q;
    assign busy          = busy_q;
    assign instr_retired = retired_q;
    assign illegal_op    = illegal_q;
    assign retire_count  = count_q;
`ifdef DISPATCH_TIMEOUT_EN
    assign timeout_err   = tmo_q;
`endif
endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// tb_instr_dispatch_fsm: directed checks of dispatch latency, illegal opcodes, done filtering, reset and retire wrap.
module tb_instr_dispatch_fsm;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        instr_ready;
    logic [3:0]  fsm_done = 4'b0000;
    logic [3:0]  fsm_start;
    logic [5:0]  source;
    logic [5:0]  dest;
    logic        busy;
    logic        instr_retired;
    logic        illegal_op;
    logic [7:0]  retire_count;
`ifdef DISPATCH_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_total = 0;
    int n_bad = 0;
    int exp_count = 0;

    instr_dispatch_fsm #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock),
        .reset(reset),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_ready(instr_ready),
        .fsm_done(fsm_done),
        .fsm_start(fsm_start),
        .source(source),
        .dest(dest),
        .busy(busy),
        .instr_retired(instr_retired),
        .illegal_op(illegal_op),
`ifdef DISPATCH_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .retire_count(retire_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic ok;
        int n_start, n_ret, cyc;
        // reset values
        step;
        step;
        reset = 1'b0;
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", fsm_start, 0);
        chk("rst_src", source, 0);
        chk("rst_dst", dest, 0);
        chk("rst_ret", instr_retired, 0);
        chk("rst_ill", illegal_op, 0);
        chk("rst_cnt", retire_count, 0);

        // MOV-imm 0x1143: start at cycle 2, done at 6, retire at 7, ready at 8
        instr = 16'h1143;
        instr_valid = 1'b1;
        step;
        instr_valid = 1'b0;
        chk("movi_c1_busy", busy, 1);
        chk("movi_c1_ready", instr_ready, 0);
        chk("movi_c1_start", fsm_start, 0);
        step;
        chk("movi_c2_start", fsm_start, 4'b0010);
        chk("movi_c2_src", source, 5);
        chk("movi_c2_dst", dest, 3);
        step;
        chk("movi_c3_start", fsm_start, 0);
        step;
        step;
        step;
        fsm_done = 4'b0010;
        chk("movi_c6_ret", instr_retired, 0);
        step;
        fsm_done = 4'b0000;
        exp_count++;
        chk("movi_c7_ret", instr_retired, 1);
        chk("movi_c7_cnt", retire_count, exp_count);
        chk("movi_c7_ready", instr_ready, 0);
        step;
        chk("movi_c8_ready", instr_ready, 1);
        chk("movi_c8_ret", instr_retired, 0);

        // illegal opcodes 0xA and the 4 boundary
        instr = 16'hA000;
        instr_valid = 1'b1;
        step;
        instr_valid = 1'b0;
        chk("ill_a_c1", illegal_op, 1);
        chk("ill_a_c1_start", fsm_start, 0);
        step;
        chk("ill_a_c2", illegal_op, 0);
        chk("ill_a_c2_ready", instr_ready, 1);
        chk("ill_a_c2_start", fsm_start, 0);
        chk("ill_a_cnt", retire_count, exp_count);
        instr = 16'h4000;
        instr_valid = 1'b1;
        step;
        instr_valid = 1'b0;
        chk("ill_4_c1", illegal_op, 1);
        step;
        chk("ill_4_c2_start", fsm_start, 0);
        chk("ill_4_c2_ready", instr_ready, 1);

        // ADD: done high only in START ignored, wrong done bits held 10 cycles, valid held while busy
        instr = {4'd2, 6'd10, 6'd20};
        instr_valid = 1'b1;
        step;
        step;
        chk("add_start", fsm_start, 4'b0100);
        chk("add_src", source, 10);
        chk("add_dst", dest, 20);
        fsm_done = 4'b0100;
        step;
        fsm_done = 4'b0011;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step;
            if (!busy || instr_retired || fsm_start != 4'b0000 || source != 6'd10) ok = 1'b0;
        end
        chk("add_hold_wait", ok, 1);
        fsm_done = 4'b0100;
        step;
        fsm_done = 4'b0000;
        instr_valid = 1'b0;
        exp_count++;
        chk("add_ret", instr_retired, 1);
        chk("add_cnt", retire_count, exp_count);
        step;
        chk("add_idle", instr_ready, 1);

        // SUB with extreme operands
        instr = {4'd3, 6'd63, 6'd0};
        instr_valid = 1'b1;
        step;
        instr_valid = 1'b0;
        step;
        chk("sub_start", fsm_start, 4'b1000);
        chk("sub_src", source, 63);
        chk("sub_dst", dest, 0);
        step;
        fsm_done = 4'b1000;
        step;
        fsm_done = 4'b0000;
        exp_count++;
        chk("sub_ret", instr_retired, 1);
        chk("sub_cnt", retire_count, exp_count);
        step;

        // reset in WAIT, then a fresh instruction
        instr = {4'd0, 6'd7, 6'd9};
        instr_valid = 1'b1;
        step;
        instr_valid = 1'b0;
        step;
        step;
        step;
        chk("rw_busy_pre", busy, 1);
        reset = 1'b1;
        step;
        reset = 1'b0;
        exp_count = 0;
        chk("rw_busy", busy, 0);
        chk("rw_start", fsm_start, 0);
        chk("rw_src", source, 0);
        chk("rw_dst", dest, 0);
        chk("rw_cnt", retire_count, 0);
        chk("rw_ready", instr_ready, 1);
        instr = {4'd1, 6'd2, 6'd4};
        instr_valid = 1'b1;
        step;
        instr_valid = 1'b0;
        step;
        chk("rw_new_start", fsm_start, 4'b0010);
        step;
        fsm_done = 4'b0010;
        step;
        fsm_done = 4'b0000;
        exp_count++;
        chk("rw_new_ret", instr_retired, 1);
        chk("rw_new_cnt", retire_count, exp_count);
        step;

        // no done: watchdog abort or indefinite WAIT
        instr = {4'd0, 6'd1, 6'd1};
        instr_valid = 1'b1;
        step;
        instr_valid = 1'b0;
        step;
`ifdef DISPATCH_TIMEOUT_EN
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            if (!busy || timeout_err) ok = 1'b0;
        end
        chk("tmo_wait4", ok, 1);
        step;
        chk("tmo_pulse", timeout_err, 1);
        chk("tmo_idle", busy, 0);
        chk("tmo_noret", instr_retired, 0);
        step;
        chk("tmo_one", timeout_err, 0);
        chk("tmo_cnt", retire_count, exp_count);
`else
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step;
            if (!busy || instr_retired || instr_ready) ok = 1'b0;
        end
        chk("hold_100", ok, 1);
        fsm_done = 4'b0001;
        step;
        fsm_done = 4'b0000;
        exp_count++;
        chk("hold_ret", instr_retired, 1);
        chk("hold_cnt", retire_count, exp_count);
        step;
`endif

        // 256 back-to-back MOVs, valid and done held throughout
        reset = 1'b1;
        step;
        reset = 1'b0;
        instr = {4'd0, 6'd1, 6'd2};
        instr_valid = 1'b1;
        fsm_done = 4'b0001;
        n_start = 0;
        n_ret = 0;
        cyc = 0;
        ok = 1'b1;
        while (n_ret < 256 && cyc < 3000) begin
            step;
            cyc++;
            if (fsm_start != 4'b0000) begin
                n_start++;
                if (fsm_start != 4'b0001) ok = 1'b0;
            end
            if (instr_retired) begin
                n_ret++;
                if (n_ret == 255) chk("wrap_255", retire_count, 255);
                if (n_ret == 256) instr_valid = 1'b0;
            end
        end
        chk("wrap_nret", n_ret, 256);
        chk("wrap_nstart", n_start, 256);
        chk("wrap_onehot", ok, 1);
        chk("wrap_cnt", retire_count, 0);
        fsm_done = 4'b0000;
        step;
        step;
        chk("wrap_idle", busy, 0);
        chk("wrap_nostart", fsm_start, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
